// File: rtl/ocr_dense_argmax.sv
// Fully-connected 784->10 classifier: walks the collector image, MACs against
// an external weight memory per class and reports the argmax. Optional per-class
// bias words are enabled with the OCR_BIAS_EN macro.
module ocr_dense_argmax #(
  parameter int N_INPUTS  = 784,
  parameter int N_CLASSES = 10,
  parameter int W_WIDTH   = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_L,
  input  logic                        i_Data_Ready,
  output logic [9:0]                  o_Data_Addr,
  input  logic signed [31:0]          i_Data_Element,
  output logic [12:0]                 o_Weight_Addr,
  input  logic signed [W_WIDTH-1:0]   i_Weight,
  output logic                        o_Busy,
  output logic                        o_Valid,
  output logic [3:0]                  o_Class,
  output logic signed [ACC_WIDTH-1:0] o_Score
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_ACC_END = 3'd2,
    S_BIAS    = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [9:0]  LAST_PIXEL = 10'(N_INPUTS - 1);
  localparam logic [3:0]  LAST_CLASS = 4'(N_CLASSES - 1);
  localparam logic [12:0] BIAS_BASE  = 13'(N_CLASSES * N_INPUTS);

  state_t                        r_state;
  state_t                        w_next_state;
  logic                          r_ready_d;
  logic [3:0]                    r_class;
  logic [9:0]                    r_pixel;
  logic signed [31:0]            r_elem;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic signed [ACC_WIDTH-1:0]   r_best;
  logic [3:0]                    r_best_class;
  logic                          r_valid;

  logic                          w_start;
  logic signed [ACC_WIDTH-1:0]   w_weight_ext;
  logic signed [ACC_WIDTH-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0]   w_final;
  logic                          w_better;

  assign w_start      = (r_state == S_IDLE) && i_Data_Ready && !r_ready_d;
  assign w_weight_ext = {{(ACC_WIDTH-W_WIDTH){i_Weight[W_WIDTH-1]}}, i_Weight};
  // Low ACC_WIDTH bits of the full 32xW product equal the product of the
  // sign-extended operands truncated to ACC_WIDTH.
  assign w_prod       = r_elem * w_weight_ext;

`ifdef OCR_BIAS_EN
  // Bias word requested in BIAS arrives from the registered memory during COMPARE.
  assign w_final = r_acc + w_weight_ext;
`else
  assign w_final = r_acc;
`endif

  assign w_better = (r_class == 4'd0) || (w_final > r_best);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next_state = S_RUN;
      S_RUN:     if (r_pixel == LAST_PIXEL) w_next_state = S_ACC_END;
`ifdef OCR_BIAS_EN
      S_ACC_END: w_next_state = S_BIAS;
      S_BIAS:    w_next_state = S_COMPARE;
`else
      S_ACC_END: w_next_state = S_COMPARE;
`endif
      S_COMPARE: w_next_state = (r_class == LAST_CLASS) ? S_DONE : S_RUN;
      S_DONE:    if (!i_Data_Ready) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_Busy        = 1'b0;
    o_Data_Addr   = 10'd0;
    o_Weight_Addr = 13'd0;
    case (r_state)
      S_RUN: begin
        o_Busy        = 1'b1;
        o_Data_Addr   = r_pixel;
        o_Weight_Addr = 13'(r_class) * 13'(N_INPUTS) + 13'(r_pixel);
      end
      S_ACC_END: o_Busy = 1'b1;
      S_BIAS: begin
        o_Busy        = 1'b1;
        o_Weight_Addr = BIAS_BASE + 13'(r_class);
      end
      S_COMPARE: o_Busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_ready_d    <= 1'b0;
      r_class      <= 4'd0;
      r_pixel      <= 10'd0;
      r_elem       <= '0;
      r_acc        <= '0;
      r_best       <= '0;
      r_best_class <= 4'd0;
      r_valid      <= 1'b0;
    end else begin
      r_ready_d <= i_Data_Ready;
      // Valid drops on the same edge that returns DONE to IDLE.
      r_valid   <= (r_state == S_DONE) && i_Data_Ready;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_class <= 4'd0;
            r_pixel <= 10'd0;
            r_acc   <= '0;
          end
        end
        S_RUN: begin
          r_elem <= i_Data_Element;
          if (r_pixel != 10'd0) r_acc <= r_acc + w_prod;
          if (r_pixel != LAST_PIXEL) r_pixel <= r_pixel + 10'd1;
        end
        S_ACC_END: r_acc <= r_acc + w_prod;
        S_COMPARE: begin
          if (w_better) begin
            r_best       <= w_final;
            r_best_class <= r_class;
          end
          if (r_class != LAST_CLASS) begin
            r_class <= r_class + 4'd1;
            r_pixel <= 10'd0;
            r_acc   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Valid = r_valid;
  assign o_Class = r_best_class;
  assign o_Score = r_best;

endmodule

// File: tb/tb_ocr_dense_argmax.sv
// Directed bench for ocr_dense_argmax: table of image/weight patterns with
// hand-computed argmax results, plus reset and re-trigger sequences.
module tb_ocr_dense_argmax;

`ifdef OCR_BIAS_EN
  localparam int LATENCY = 7871;
`else
  localparam int LATENCY = 7861;
`endif

  logic               clk;
  logic               rst_n;
  logic               ready;
  logic [9:0]         data_addr;
  logic signed [31:0] data_element;
  logic [12:0]        weight_addr;
  logic signed [15:0] weight;
  logic               busy;
  logic               valid;
  logic [3:0]         out_class;
  logic signed [31:0] out_score;

  logic signed [31:0] img  [0:1023];
  logic signed [15:0] wmem [0:8191];

  int n_applied = 0;
  int n_miss    = 0;

  ocr_dense_argmax dut (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_Data_Ready   (ready),
    .o_Data_Addr    (data_addr),
    .i_Data_Element (data_element),
    .o_Weight_Addr  (weight_addr),
    .i_Weight       (weight),
    .o_Busy         (busy),
    .o_Valid        (valid),
    .o_Class        (out_class),
    .o_Score        (out_score)
  );

  // clock / memories
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_element = img[data_addr];
  always @(posedge clk) weight <= wmem[weight_addr];

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int                 pat;
    logic [3:0]         exp_class;
    logic signed [31:0] exp_score;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int widx(input int c, input int p);
    return c * 784 + p;
  endfunction

  task automatic load_pattern(input int pat);
    for (int i = 0; i < 1024; i++) img[i] = 0;
    for (int i = 0; i < 8192; i++) wmem[i] = 0;
    case (pat)
      0: for (int i = 0; i < 7840; i++) wmem[i] = 16'($urandom_range(65535));
      1: begin
        img[5] = 1;
        wmem[widx(7, 5)] = 300;
      end
      2: begin
        img[0] = 1; img[1] = 1;
        wmem[widx(3, 0)] = 100; wmem[widx(3, 1)] = 100;
        wmem[widx(8, 0)] = 100; wmem[widx(8, 1)] = 100;
      end
      3: begin
        for (int i = 0; i < 784; i++) img[i] = 1;
        for (int i = 0; i < 7840; i++) wmem[i] = -16'sd1;
        wmem[widx(4, 0)] = 1;
      end
      4: begin
        img[0] = -3; img[783] = 2;
        wmem[widx(1, 0)] = 5;
        wmem[widx(6, 0)] = -7;  wmem[widx(6, 783)] = -1;
        wmem[widx(9, 783)] = 10;
      end
      5: begin
        img[0] = 32'sh7FFF_FFFF;
        wmem[widx(2, 0)] = -2;
      end
      default: ;
    endcase
  endtask

  task automatic drop_ready();
    @(negedge clk);
    ready = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Raises ready and counts edges after the start-sample edge until o_Valid.
  task automatic run_inference(input bit toggle_mid, output int cycles);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk);
    cycles = 0;
    while (cycles < 9000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (toggle_mid && cycles == 100) ready = 1'b0;
      if (toggle_mid && cycles == 110) ready = 1'b1;
      if (toggle_mid && cycles == 200) begin
        check("busy_mid_run", busy, 1);
        check("valid_mid_run", valid, 0);
      end
      if (valid) break;
    end
  endtask

  initial begin
    int cyc;

    vecs[0] = '{pat: 0, exp_class: 4'd0, exp_score: 0};
    vecs[1] = '{pat: 1, exp_class: 4'd7, exp_score: 300};
    vecs[2] = '{pat: 2, exp_class: 4'd3, exp_score: 200};
    vecs[3] = '{pat: 5, exp_class: 4'd2, exp_score: 2};
    vecs[4] = '{pat: 4, exp_class: 4'd9, exp_score: 20};

    // reset
    rst_n = 1'b0;
    ready = 1'b0;
    load_pattern(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_class", out_class, 0);
    check("rst_score", out_score, 0);
    check("rst_data_addr", data_addr, 0);
    check("rst_weight_addr", weight_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // table vectors
    for (int v = 0; v < 5; v++) begin
      load_pattern(vecs[v].pat);
      drop_ready();
      run_inference(1'b0, cyc);
      check($sformatf("v%0d_latency", v), cyc, LATENCY);
      check($sformatf("v%0d_class", v), out_class, vecs[v].exp_class);
      check($sformatf("v%0d_score", v), out_score, vecs[v].exp_score);
      check($sformatf("v%0d_busy_done", v), busy, 0);
    end

    // DONE held while ready stays high, then re-trigger
    repeat (20) @(posedge clk);
    #1;
    check("hold_valid", valid, 1);
    check("hold_class", out_class, 9);
    @(negedge clk);
    ready = 1'b0;
    @(posedge clk);
    #1;
    check("valid_clear", valid, 0);
    check("class_hold_idle", out_class, 9);
    check("score_hold_idle", out_score, 20);
    load_pattern(1);
    repeat (2) @(posedge clk);
    run_inference(1'b1, cyc);
    check("retrig_latency", cyc, LATENCY);
    check("retrig_class", out_class, 7);
    check("retrig_score", out_score, 300);

    // reset during class 5
    load_pattern(3);
    drop_ready();
    @(negedge clk);
    ready = 1'b1;
    repeat (4031) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_class", out_class, 4);
    #2;
    rst_n = 1'b0;
    ready = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_class", out_class, 0);
    check("mid_rst_score", out_score, 0);
    check("mid_rst_data_addr", data_addr, 0);
    check("mid_rst_weight_addr", weight_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle_busy", busy, 0);
    run_inference(1'b0, cyc);
    check("restart_latency", cyc, LATENCY);
    check("restart_class", out_class, 4);
    check("restart_score", out_score, -782);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/ocr_dense_argmax.md
Name: ocr_dense_argmax

Overview:
Downstream consumer of the UART data collector. Once the 784-element binary image is ready, this block walks it by address, multiplies each element by a signed weight from an external weight memory, and accumulates one score per class for 10 classes. It then outputs the argmax class and its score for display or UART reporting. This is the single fully-connected classification stage of the OCR datapath.

Parameters:
N_INPUTS, 784, image elements per class (collector address range 0..N_INPUTS-1)
N_CLASSES, 10, number of output classes/neurons
W_WIDTH, 16, signed weight width
ACC_WIDTH, 32, signed accumulator and score width

Ports:
i_Clock  input  1  system clock; all state changes on the rising edge
i_Rst_L  input  1  asynchronous active-low reset
i_Data_Ready  input  1  collector image-complete level; a rising edge starts one inference
o_Data_Addr  output  10  element address driven to the collector
i_Data_Element  input  32  signed element from the collector, combinational from o_Data_Addr
o_Weight_Addr  output  13  weight address = class*N_INPUTS + pixel
i_Weight  input  W_WIDTH  signed weight; registered memory, valid 1 cycle after o_Weight_Addr
o_Busy  output  1  high from RUN entry until DONE
o_Valid  output  1  result valid level
o_Class  output  4  argmax class index 0..N_CLASSES-1
o_Score  output  ACC_WIDTH  winning accumulated score

Behaviour:
- Reset, asynchronous and mid-operation alike: state IDLE; o_Busy, o_Valid, o_Class, o_Score, o_Data_Addr and o_Weight_Addr all 0; accumulator 0; best score register 0; class/pixel counters 0; edge detector delayed copy 0.
- Start detection: i_Data_Ready is registered. A start is i_Data_Ready=1 while the delayed copy is 0, sampled in IDLE only. Edges in any other state are ignored.
- States: IDLE, RUN, ACC_END, COMPARE, DONE.
- IDLE to RUN on start. Set class=0, pixel=0, accumulator=0.
- RUN: drive o_Data_Addr=pixel and o_Weight_Addr=class*N_INPUTS+pixel. Register i_Data_Element in the same cycle so it aligns with i_Weight one cycle later. From the second RUN cycle onward, add product(prev element, i_Weight) to the accumulator. At pixel=N_INPUTS-1, go to ACC_END; otherwise increment pixel.
- ACC_END: add the final product, then go to COMPARE.
- COMPARE:
  - If class==0, or accumulator > best (signed, strict), load best=accumulator and best_class=class. Ties keep the lower index.
  - If class==N_CLASSES-1, go to DONE. Otherwise increment class, set pixel=0 and accumulator=0, and go to RUN.
- Per class: N_INPUTS+2 cycles. o_Valid rises exactly 1+N_CLASSES*(N_INPUTS+2) cycles after the start-sample edge, which is 7861 cycles with the defaults.
- DONE: o_Busy=0, o_Valid=1. o_Class and o_Score hold best_class and best. Return to IDLE when i_Data_Ready=0; o_Valid clears on that transition. o_Class and o_Score hold their values until the next COMPARE at class 0 or a reset.
- Arithmetic:
  - Product is full-width signed 32×W_WIDTH, truncated to ACC_WIDTH.
  - Accumulation wraps in two's complement; there is no saturation.
- o_Data_Addr and o_Weight_Addr are 0 in every state except RUN.
- o_Busy is high during RUN, ACC_END and COMPARE.

Optional Feature:
OCR_BIAS_EN
- Defined: after ACC_END, add a BIAS state that drives o_Weight_Addr=N_CLASSES*N_INPUTS+class. The next cycle adds i_Weight, sign-extended, to the accumulator before COMPARE.
  - Per class: N_INPUTS+3 cycles.
  - Total latency with defaults: 7871 cycles.
  - The weight memory holds 7850 words.
- Undefined: no BIAS state, no bias words, latency 7861.

Test Plan:
- All-zero image, arbitrary weights, i_Data_Ready rising → o_Valid at cycle 7861, o_Class=0, o_Score=0 (all-tie case).
- Only element 5 = 1; weight(7,5)=+300, all other weights 0 → o_Class=7, o_Score=300.
- Elements 0 and 1 = 1; classes 3 and 8 each get weight 100 at both pixels → o_Score=200, o_Class=3 (lower index wins the tie).
- All elements 1; all weights −1 except class 4 at pixel 0 = +1 → every score negative; o_Class=4, o_Score=−782.
- Reset pulse during class 5 RUN → all outputs 0 immediately. Next i_Data_Ready edge restarts from class 0 with correct result and latency.
- Hold i_Data_Ready high after DONE, toggle it low then high → stays in DONE until low; second edge runs a new inference and o_Valid clears during it.
